// File: rtl/adc_pkg.sv
// Shared acquisition definitions: sequencer state encoding, register map,
// AXI response codes and a byte-strobe merge helper.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_e;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_NPKT   = 8'h04;
  localparam logic [7:0] REG_GAP    = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;
  localparam logic [7:0] REG_PKTCNT = 8'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_EXT_TRIG = 2;
  localparam int CTRL_IRQ_MASK = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// AXI4-Lite control/status bus (32-bit address and data).
interface acq_sequencer_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/acq_sequencer_regs.sv
// AXI4-Lite register file for the acquisition sequencer; one outstanding
// write and one outstanding read. ACQ_SEQUENCER_IRQ_EN adds CTRL.IRQ_MASK.
module acq_sequencer_regs
  import adc_pkg::*;
#(
  parameter int GAP_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  acq_sequencer_if.slave       s_axi,
  input  acq_state_e           state,
  input  logic                 busy,
  input  logic                 done,
  input  logic [31:0]          pktcnt,
  output logic                 start,
  output logic                 abort,
  output logic                 ext_trig_en,
  output logic [31:0]          npkt,
  output logic [GAP_WIDTH-1:0] gap
`ifdef ACQ_SEQUENCER_IRQ_EN
  ,
  output logic                 irq_mask
`endif
);

  localparam logic [5:0] IDX_CTRL   = REG_CTRL[7:2];
  localparam logic [5:0] IDX_NPKT   = REG_NPKT[7:2];
  localparam logic [5:0] IDX_GAP    = REG_GAP[7:2];
  localparam logic [5:0] IDX_STATUS = REG_STATUS[7:2];
  localparam logic [5:0] IDX_PKTCNT = REG_PKTCNT[7:2];

  logic                 awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                 aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [5:0]           aw_idx_q, aw_idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 start_q, start_d, abort_q, abort_d;
  logic                 ext_trig_en_q, ext_trig_en_d;
  logic [31:0]          npkt_q, npkt_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic                 irq_mask_rd;
  logic                 unused_bits;

`ifdef ACQ_SEQUENCER_IRQ_EN
  logic irq_mask_q, irq_mask_d;
  assign irq_mask_rd = irq_mask_q;
  assign irq_mask    = irq_mask_q;
`else
  assign irq_mask_rd = 1'b0;
`endif

  always_comb begin
    awready_d     = s_axi.awvalid & ~awready_q & ~aw_full_q & ~bvalid_q;
    wready_d      = s_axi.wvalid & ~wready_q & ~w_full_q & ~bvalid_q;
    arready_d     = s_axi.arvalid & ~arready_q & ~rvalid_q;
    aw_full_d     = aw_full_q;
    aw_idx_d      = aw_idx_q;
    w_full_d      = w_full_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    start_d       = 1'b0;
    abort_d       = 1'b0;
    ext_trig_en_d = ext_trig_en_q;
    npkt_d        = npkt_q;
    gap_d         = gap_q;
`ifdef ACQ_SEQUENCER_IRQ_EN
    irq_mask_d    = irq_mask_q;
`endif

    if (s_axi.awvalid & awready_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[7:2];
    end
    if (s_axi.wvalid & wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    // Commit once both halves of the write have landed.
    if (aw_full_q & w_full_q & ~bvalid_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (aw_idx_q)
        IDX_CTRL: if (wstrb_q[0]) begin
          start_d       = wdata_q[CTRL_START];
          abort_d       = wdata_q[CTRL_ABORT];
          ext_trig_en_d = wdata_q[CTRL_EXT_TRIG];
`ifdef ACQ_SEQUENCER_IRQ_EN
          irq_mask_d    = wdata_q[CTRL_IRQ_MASK];
`endif
        end
        IDX_NPKT: if (busy) bresp_d = RESP_SLVERR;
                  else      npkt_d  = apply_wstrb(npkt_q, wdata_q, wstrb_q);
        IDX_GAP:  if (busy) bresp_d = RESP_SLVERR;
                  else      gap_d   = GAP_WIDTH'(apply_wstrb(32'(gap_q), wdata_q, wstrb_q));
        default:  bresp_d = RESP_SLVERR;
      endcase
    end
    if (bvalid_q & s_axi.bready) bvalid_d = 1'b0;

    if (s_axi.arvalid & arready_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (s_axi.araddr[7:2])
        IDX_CTRL:   rdata_d = {28'd0, irq_mask_rd, ext_trig_en_q, 2'b00};
        IDX_NPKT:   rdata_d = npkt_q;
        IDX_GAP:    rdata_d = 32'(gap_q);
        IDX_STATUS: rdata_d = {28'd0, done, state};
        IDX_PKTCNT: rdata_d = pktcnt;
        default:    rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q & s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      arready_q     <= 1'b0;
      aw_full_q     <= 1'b0;
      aw_idx_q      <= '0;
      w_full_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      ext_trig_en_q <= 1'b0;
      npkt_q        <= '0;
      gap_q         <= '0;
`ifdef ACQ_SEQUENCER_IRQ_EN
      irq_mask_q    <= 1'b0;
`endif
    end else begin
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      arready_q     <= arready_d;
      aw_full_q     <= aw_full_d;
      aw_idx_q      <= aw_idx_d;
      w_full_q      <= w_full_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      start_q       <= start_d;
      abort_q       <= abort_d;
      ext_trig_en_q <= ext_trig_en_d;
      npkt_q        <= npkt_d;
      gap_q         <= gap_d;
`ifdef ACQ_SEQUENCER_IRQ_EN
      irq_mask_q    <= irq_mask_d;
`endif
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign start         = start_q;
  assign abort         = abort_q;
  assign ext_trig_en   = ext_trig_en_q;
  assign npkt          = npkt_q;
  assign gap           = gap_q;

  // Decode looks only at address bits [7:2].
  assign unused_bits = ^{s_axi.awaddr[31:8], s_axi.awaddr[1:0], s_axi.araddr[31:8],
                         s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot};

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: gates an ADC stream into packets under FSM control.
// Define ACQ_SEQUENCER_IRQ_EN for the irq output and CTRL.IRQ_MASK.
module acq_sequencer
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  input  logic                  pkt_last,
  input  logic                  trigger,
  acq_sequencer_if.slave        s_axi_lite,
  output logic                  busy
`ifdef ACQ_SEQUENCER_IRQ_EN
  ,
  output logic                  irq
`endif
);

  acq_state_e           state_q, state_d;
  logic                 trig_s1_q, trig_s2_q, trig_s3_q;
  logic [31:0]          pktcnt_q, pktcnt_d;
  logic                 done_q, done_d;
  logic                 abort_pend_q, abort_pend_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                 start, abort, ext_trig_en;
  logic [31:0]          npkt;
  logic [GAP_WIDTH-1:0] gap;
  logic                 run, pkt_done, trig_rise, npkt_hit;

  acq_sequencer_regs #(.GAP_WIDTH(GAP_WIDTH)) u_regs (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axi       (s_axi_lite),
    .state       (state_q),
    .busy        (busy),
    .done        (done_q),
    .pktcnt      (pktcnt_q),
    .start       (start),
    .abort       (abort),
    .ext_trig_en (ext_trig_en),
    .npkt        (npkt),
    .gap         (gap)
`ifdef ACQ_SEQUENCER_IRQ_EN
    ,
    .irq_mask    (irq_mask)
`endif
  );

  assign run                = (state_q == ST_RUN);
  assign busy               = (state_q != ST_IDLE);
  assign m_axis_data_tdata  = s_axis_data_tdata;
  assign m_axis_data_tvalid = s_axis_data_tvalid & run;
  assign s_axis_data_tready = m_axis_data_tready & run;
  assign pkt_done           = run & pkt_last & s_axis_data_tvalid & m_axis_data_tready;
  assign trig_rise          = trig_s2_q & ~trig_s3_q;
  // 33-bit compare so a saturated counter never wraps into a false match.
  assign npkt_hit = (npkt != 32'd0) && (({1'b0, pktcnt_q} + 33'd1) == {1'b0, npkt});

  always_comb begin
    state_d      = state_q;
    pktcnt_d     = pktcnt_q;
    done_d       = done_q;
    abort_pend_d = abort_pend_q;
    gap_cnt_d    = gap_cnt_q;
    if (pkt_done && pktcnt_q != '1) pktcnt_d = pktcnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          pktcnt_d = '0;
          done_d   = 1'b0;
          state_d  = ext_trig_en ? ST_ARMED : ST_RUN;
        end
      end
      ST_ARMED: begin
        if (abort)          state_d = ST_IDLE;
        else if (trig_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A packet in flight always completes; abort takes effect at its tlast.
        if (pkt_done) begin
          if (npkt_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (abort || abort_pend_q) begin
            state_d = ST_IDLE;
          end else if (gap != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap;
          end
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort)                             state_d = ST_IDLE;
        else if (gap_cnt_q <= GAP_WIDTH'(1))   state_d = ST_RUN;
        else                                   gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      trig_s1_q    <= 1'b0;
      trig_s2_q    <= 1'b0;
      trig_s3_q    <= 1'b0;
      pktcnt_q     <= '0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      trig_s1_q    <= trigger;
      trig_s2_q    <= trig_s1_q;
      trig_s3_q    <= trig_s2_q;
      pktcnt_q     <= pktcnt_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef ACQ_SEQUENCER_IRQ_EN
  logic irq_mask, irq_q, irq_d;
  assign irq_d = (state_q == ST_RUN) && (state_d == ST_DONE) && !irq_mask;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: register access, packet counting, gaps,
// external trigger, abort, busy write protection and reset behaviour.
module tb_acq_sequencer;
  import adc_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic        pkt_last, trigger, busy;
`ifdef ACQ_SEQUENCER_IRQ_EN
  logic        irq;
`endif

  acq_sequencer_if axil();

  int n_tests = 0;
  int n_fail  = 0;
  int beat_cnt = 0;

  always #5 aclk = ~aclk;

  acq_sequencer #(.DATA_WIDTH(32), .GAP_WIDTH(16)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .pkt_last           (pkt_last),
    .trigger            (trigger),
    .s_axi_lite         (axil),
    .busy               (busy)
`ifdef ACQ_SEQUENCER_IRQ_EN
    ,
    .irq                (irq)
`endif
  );

  always @(negedge aclk) if (m_tvalid && m_tready) beat_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_wr(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
    logic aw_go, w_go, got;
    axil.awaddr = {24'd0, addr}; axil.awprot = 3'd0; axil.awvalid = 1'b1;
    axil.wdata  = data;          axil.wstrb  = 4'hF; axil.wvalid  = 1'b1;
    for (int i = 0; i < 20 && (axil.awvalid || axil.wvalid); i++) begin
      @(negedge aclk);
      aw_go = axil.awready;
      w_go  = axil.wready;
      tick();
      if (aw_go) axil.awvalid = 1'b0;
      if (w_go)  axil.wvalid  = 1'b0;
    end
    axil.bready = 1'b1;
    got  = 1'b0;
    resp = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (axil.bvalid) begin got = 1'b1; resp = axil.bresp; end
      tick();
    end
    axil.bready = 1'b0;
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    if (!got) chk("wr_bvalid_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic axi_rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ar_go, got;
    axil.araddr = {24'd0, addr}; axil.arprot = 3'd0; axil.arvalid = 1'b1;
    for (int i = 0; i < 20 && axil.arvalid; i++) begin
      @(negedge aclk);
      ar_go = axil.arready;
      tick();
      if (ar_go) axil.arvalid = 1'b0;
    end
    axil.rready = 1'b1;
    got  = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (axil.rvalid) begin got = 1'b1; data = axil.rdata; resp = axil.rresp; end
      tick();
    end
    axil.rready  = 1'b0;
    axil.arvalid = 1'b0;
    if (!got) chk("rd_rvalid_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    axi_wr(addr, data, resp);
    chk("wr_okay", {30'd0, resp}, {30'd0, RESP_OKAY});
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    logic [1:0]  resp;
    axi_rd(addr, data, resp);
    chk(tag, data, exp);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    logic hs;
    s_tdata = data; s_tvalid = 1'b1; pkt_last = last; hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk);
      hs = s_tready;
      if (hs) chk("m_tdata", m_tdata, data);
      tick();
    end
    s_tvalid = 1'b0;
    pkt_last = 1'b0;
    if (!hs) chk("beat_timeout", {31'd0, hs}, 32'd1);
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) send_beat(base + b, (b == n - 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    logic [1:0]  resp;
    int          b0, n;
    logic        seen;

    aresetn = 1'b0;
    s_tdata = 32'd0; s_tvalid = 1'b1; m_tready = 1'b1;
    pkt_last = 1'b0; trigger = 1'b0;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b1;
    axil.wdata  = '0; axil.wstrb  = '0; axil.wvalid  = 1'b1; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b1; axil.rready = 1'b0;

    // Reset state with every input trying to provoke activity
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy",    {31'd0, busy},         32'd0);
    chk("rst_s_tready", {31'd0, s_tready},    32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid},    32'd0);
    chk("rst_awready", {31'd0, axil.awready}, 32'd0);
    chk("rst_wready",  {31'd0, axil.wready},  32'd0);
    chk("rst_arready", {31'd0, axil.arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, axil.bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, axil.rvalid},  32'd0);
    s_tvalid = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    tick();
    rd_chk("rst_status", REG_STATUS, 32'd0);
    rd_chk("rst_pktcnt", REG_PKTCNT, 32'd0);
    rd_chk("rst_npkt",   REG_NPKT,   32'd0);

    // NPKT=3, GAP=0: 12 beats then DONE for one cycle
    wr(REG_NPKT, 32'd3);
    wr(REG_GAP, 32'd0);
    wr(REG_CTRL, 32'h1);
    rd_chk("t1_status_run", REG_STATUS, 32'd2);
    b0 = beat_cnt;
    for (int p = 0; p < 3; p++) send_pkt(4, 32'hA000_0000 + 32'(p * 16));
    @(negedge aclk);
    chk("t1_busy_in_done", {31'd0, busy}, 32'd1);
`ifdef ACQ_SEQUENCER_IRQ_EN
    chk("t1_irq_pulse", {31'd0, irq}, 32'd1);
`endif
    @(negedge aclk);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_beats", 32'(beat_cnt - b0), 32'd12);
    rd_chk("t1_pktcnt", REG_PKTCNT, 32'd3);
    rd_chk("t1_status_done", REG_STATUS, 32'd8);

    // GAP=5, NPKT=2: stream blocked exactly 5 cycles between packets
    wr(REG_GAP, 32'd5);
    wr(REG_NPKT, 32'd2);
    rd_chk("t2_gap_rb", REG_GAP, 32'd5);
    wr(REG_CTRL, 32'h1);
    rd_chk("t2_status_cleared", REG_STATUS, 32'd2);
    send_pkt(4, 32'hB000_0000);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      if (s_tready) seen = 1'b1; else n++;
      tick();
    end
    chk("t2_gap_cycles", 32'(n), 32'd5);
    send_pkt(4, 32'hB100_0000);
    repeat (2) tick();
    rd_chk("t2_pktcnt", REG_PKTCNT, 32'd2);
    rd_chk("t2_status_done", REG_STATUS, 32'd8);

    // CTRL bit3 exists only with the irq option
    wr(REG_CTRL, 32'h8);
`ifdef ACQ_SEQUENCER_IRQ_EN
    rd_chk("ctrl_bit3", REG_CTRL, 32'h8);
`else
    rd_chk("ctrl_bit3", REG_CTRL, 32'h0);
`endif

    // External trigger: nothing passes while ARMED; RUN 3 edges after rise
    wr(REG_GAP, 32'd0);
    wr(REG_NPKT, 32'd1);
    wr(REG_CTRL, 32'h5);
    rd_chk("t3_status_armed", REG_STATUS, 32'd1);
    s_tvalid = 1'b1;
    b0 = beat_cnt;
    repeat (100) tick();
    s_tvalid = 1'b0;
    chk("t3_no_beats", 32'(beat_cnt - b0), 32'd0);
    trigger = 1'b1;
    tick();
    tick();
    @(negedge aclk);
    chk("t3_edge2_blocked", {31'd0, s_tready}, 32'd0);
    tick();
    @(negedge aclk);
    chk("t3_edge3_run", {31'd0, s_tready}, 32'd1);
    trigger = 1'b0;
    send_pkt(2, 32'hC000_0000);
    repeat (2) tick();
    rd_chk("t3_status_done", REG_STATUS, 32'd8);
    rd_chk("t3_pktcnt", REG_PKTCNT, 32'd1);

    // Continuous mode, abort mid-packet: packet finishes, then IDLE, no DONE
    wr(REG_NPKT, 32'd0);
    wr(REG_CTRL, 32'h1);
    send_pkt(4, 32'hD000_0000);
    send_beat(32'hD100_0000, 1'b0);
    send_beat(32'hD100_0001, 1'b0);
    wr(REG_CTRL, 32'h2);
    rd_chk("t4_still_run", REG_STATUS, 32'd2);
    b0 = beat_cnt;
    send_beat(32'hD100_0002, 1'b0);
    send_beat(32'hD100_0003, 1'b1);
    @(negedge aclk);
    chk("t4_idle_after_last", {31'd0, busy}, 32'd0);
    chk("t4_tail_beats", 32'(beat_cnt - b0), 32'd2);
    rd_chk("t4_status", REG_STATUS, 32'd0);
    rd_chk("t4_pktcnt", REG_PKTCNT, 32'd2);

    // Writes while busy and bad addresses are rejected
    wr(REG_CTRL, 32'h1);
    send_pkt(2, 32'hE000_0000);
    send_beat(32'hE100_0000, 1'b0);
    axi_wr(REG_NPKT, 32'd7, resp);
    chk("t5_npkt_busy_resp", {30'd0, resp}, 32'd2);
    axi_wr(REG_GAP, 32'd9, resp);
    chk("t5_gap_busy_resp", {30'd0, resp}, 32'd2);
    rd_chk("t5_npkt_kept", REG_NPKT, 32'd0);
    rd_chk("t5_gap_kept", REG_GAP, 32'd0);
    axi_rd(8'h14, data, resp);
    chk("t5_rd_unmapped_resp", {30'd0, resp}, 32'd2);
    axi_wr(REG_STATUS, 32'd1, resp);
    chk("t5_wr_status_resp", {30'd0, resp}, 32'd2);
    axi_wr(8'h20, 32'd1, resp);
    chk("t5_wr_unmapped_resp", {30'd0, resp}, 32'd2);
    rd_chk("t5_pktcnt", REG_PKTCNT, 32'd1);

    // Reset during RUN: stream gated immediately, packet abandoned
    s_tvalid = 1'b1;
    @(negedge aclk);
    chk("t6_pre_rst_m_tvalid", {31'd0, m_tvalid}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("t6_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge aclk);
    s_tvalid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    tick();
    rd_chk("t6_status", REG_STATUS, 32'd0);
    rd_chk("t6_pktcnt", REG_PKTCNT, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
